fde_sequencer: RTL

- Parametrised multi-cycle control sequencer; next-generation replacement for the opcode-decode control unit.
- Drives the datapath (PC, IR, register file, ALU, flag register, data memory) through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK phases.
- Adds a memory-ready handshake with timeout, branch resolution from flags, run/pause at instruction boundaries, an illegal-opcode trap, and a retired-instruction counter.

---
 rtl/fde_sequencer.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/fde_sequencer.sv
// rtl/fde_sequencer.sv - multi-cycle fetch/decode/execute/memory/writeback control sequencer
module fde_sequencer #(
  parameter int OP_W    = 4,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [OP_W-1:0]  op,
  input  logic             immed_in,
  input  logic             flag_eq,
  input  logic             flag_lt,
  input  logic             flag_gt,
  input  logic             mem_ready,
  output logic             fetch,
  output logic             decode,
  output logic             execute,
  output logic             memory,
  output logic             writeback,
  output logic             mem_en,
  output logic             read_write,
  output logic             ir_en,
  output logic             pc_en,
  output logic             pc_sel,
  output logic             w_en,
  output logic             write_sel,
  output logic [OP_W-1:0]  alu_func,
  output logic             immed_sel,
  output logic             flag_en,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  localparam int WAIT_W = $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  localparam logic [OP_W-1:0] OP_JMP = OP_W'(0);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(1);
  localparam logic [OP_W-1:0] OP_LD  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_ST  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_MOV = OP_W'(10);
  localparam logic [OP_W-1:0] OP_BE  = OP_W'(11);
  localparam logic [OP_W-1:0] OP_BNE = OP_W'(12);
  localparam logic [OP_W-1:0] OP_BLT = OP_W'(13);
  localparam logic [OP_W-1:0] OP_BGT = OP_W'(14);
  localparam logic [OP_W-1:0] OP_CMP = OP_W'(15);
  localparam logic [OP_W-1:0] OP_MAX = OP_W'(15);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_ERROR
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [WAIT_W-1:0]  r_wait;
  logic [OP_W-1:0]    r_op_q;
  logic               r_imm_q;
  logic [CNT_W-1:0]   r_retired;

  logic               w_illegal;
  logic               w_timeout;
  logic               w_is_ld;
  logic               w_is_st;
  logic               w_writes_reg;
  logic               w_taken;

  // Codes above 4'hF only exist when the opcode field is wider than 4 bits.
  assign w_illegal    = (OP_W > 4) && (op > OP_MAX);
  assign w_timeout    = (r_wait == WAIT_LAST);
  assign w_is_ld      = (r_op_q == OP_LD);
  assign w_is_st      = (r_op_q == OP_ST);
  assign w_writes_reg = ((r_op_q >= OP_ADD) && (r_op_q <= OP_LD)) || (r_op_q == OP_MOV);
  assign retired      = r_retired;

  // Branch resolution from the flag register for the latched opcode.
  always_comb begin
    w_taken = 1'b0;
    case (r_op_q)
      OP_JMP:  w_taken = 1'b1;
      OP_BE:   w_taken = flag_eq;
      OP_BNE:  w_taken = ~flag_eq;
      OP_BLT:  w_taken = flag_lt;
      OP_BGT:  w_taken = flag_gt;
      default: w_taken = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Memory wait counter: counts stalled cycles, cleared whenever the state changes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait <= '0;
    end else if (w_next_state != r_state) begin
      r_wait <= '0;
    end else if ((r_state == S_FETCH) || (r_state == S_MEMORY)) begin
      r_wait <= r_wait + 1'b1;
    end
  end

  // Instruction fields are latched in DECODE so outputs never follow op directly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op_q  <= '0;
      r_imm_q <= 1'b0;
    end else if (r_state == S_DECODE) begin
      r_op_q  <= op;
      r_imm_q <= immed_in;
    end
  end

  // Retired-instruction counter, wraps naturally on overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_retired <= '0;
    end else if (r_state == S_WRITEBACK) begin
      r_retired <= r_retired + 1'b1;
    end
  end

  // Next-state and control strobe decode.
  always_comb begin
    w_next_state = r_state;
    fetch        = 1'b0;
    decode       = 1'b0;
    execute      = 1'b0;
    memory       = 1'b0;
    writeback    = 1'b0;
    mem_en       = 1'b0;
    read_write   = 1'b1;
    ir_en        = 1'b0;
    pc_en        = 1'b0;
    pc_sel       = 1'b0;
    w_en         = 1'b0;
    write_sel    = 1'b0;
    alu_func     = '0;
    immed_sel    = 1'b0;
    flag_en      = 1'b0;
    busy         = 1'b0;
    err          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en) w_next_state = S_FETCH;
      end
      S_FETCH: begin
        fetch  = 1'b1;
        mem_en = 1'b1;
        busy   = 1'b1;
        if (mem_ready) begin
          ir_en        = 1'b1;
          pc_en        = 1'b1;
          w_next_state = S_DECODE;
        end else if (w_timeout) begin
          w_next_state = S_ERROR;
        end
      end
      S_DECODE: begin
        decode       = 1'b1;
        busy         = 1'b1;
        w_next_state = w_illegal ? S_ERROR : S_EXECUTE;
      end
      S_EXECUTE: begin
        execute      = 1'b1;
        busy         = 1'b1;
        alu_func     = r_op_q;
        immed_sel    = r_imm_q;
        flag_en      = (r_op_q == OP_CMP);
        w_next_state = (w_is_ld || w_is_st) ? S_MEMORY : S_WRITEBACK;
      end
      S_MEMORY: begin
        memory     = 1'b1;
        mem_en     = 1'b1;
        busy       = 1'b1;
        alu_func   = r_op_q;
        read_write = ~w_is_st;
        if (mem_ready) begin
          w_next_state = S_WRITEBACK;
        end else if (w_timeout) begin
          w_next_state = S_ERROR;
        end
      end
      S_WRITEBACK: begin
        writeback    = 1'b1;
        busy         = 1'b1;
        alu_func     = r_op_q;
        w_en         = w_writes_reg;
        write_sel    = w_is_ld;
        pc_en        = w_taken;
        pc_sel       = w_taken;
        w_next_state = en ? S_FETCH : S_IDLE;
      end
      S_ERROR: begin
        err = 1'b1;
      end
      default: begin
        w_next_state = S_ERROR;
      end
    endcase
  end

endmodule
